// File: rtl/hazard_pkg.sv
// Shared types and constants for the scoreboard-based hazard unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam int unsigned LAT_ALU  = 1;
  localparam int unsigned LAT_LOAD = 2;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard: one down-counter per architectural register,
// loaded on issue and decremented toward zero every cycle.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned LAT_W    = 4,
  parameter int unsigned REG_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue,
  input  logic [REG_W-1:0] issue_rd,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  output logic [LAT_W-1:0] rs1_cnt,
  output logic [LAT_W-1:0] rs2_cnt,
  output logic [LAT_W-1:0] rd_cnt
);

  logic [LAT_W-1:0] cnt [NUM_REGS];

  // A fresh issue overwrites the counter and suppresses that register's decrement.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (reset || i == 0) begin
        cnt[i] <= '0;
      end else if (issue && issue_rd == REG_W'(i)) begin
        cnt[i] <= issue_lat;
      end else if (cnt[i] != '0) begin
        cnt[i] <= cnt[i] - LAT_W'(1);
      end
    end
  end

  assign rs1_cnt = cnt[rs1];
  assign rs2_cnt = cnt[rs2];
  assign rd_cnt  = cnt[rd];

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Decode/execute hazard control: RAW/WAW stalls from the latency scoreboard,
// EX forwarding selects, branch flushes and saturating stall/flush counters.
module scoreboard_hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_W    = $clog2(NUM_REGS),
  parameter int unsigned MAX_LAT  = 8,
  parameter int unsigned LAT_W    = $clog2(MAX_LAT + 1),
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             de_valid,
  input  logic [REG_W-1:0] de_rs1,
  input  logic [REG_W-1:0] de_rs2,
  input  logic [REG_W-1:0] de_rd,
  input  logic             de_reg_write,
  input  logic [LAT_W-1:0] de_lat,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic             ex_pc_src,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  output logic             if_stall,
  output logic             de_stall,
  output logic             de_flush,
  output logic             ex_flush,
  output logic [1:0]       ex_op1_forward,
  output logic [1:0]       ex_op2_forward,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  logic [LAT_W-1:0] rs1_cnt;
  logic [LAT_W-1:0] rs2_cnt;
  logic [LAT_W-1:0] rd_cnt;
  logic             raw;
  logic             waw;
  logic             issue;
  fwd_sel_e         op1_sel;
  fwd_sel_e         op2_sel;

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .LAT_W    (LAT_W),
    .REG_W    (REG_W)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .issue     (issue),
    .issue_rd  (de_rd),
    .issue_lat (de_lat),
    .rs1       (de_rs1),
    .rs2       (de_rs2),
    .rd        (de_rd),
    .rs1_cnt   (rs1_cnt),
    .rs2_cnt   (rs2_cnt),
    .rd_cnt    (rd_cnt)
  );

  function automatic fwd_sel_e fwd_pick(
    input logic [REG_W-1:0] rs,
    input logic             m_we,
    input logic [REG_W-1:0] m_rd,
    input logic             w_we,
    input logic [REG_W-1:0] w_rd
  );
    if (rs != '0 && m_we && m_rd == rs) return FWD_MEM;
    if (rs != '0 && w_we && w_rd == rs) return FWD_WB;
    return FWD_RF;
  endfunction

  // A count of 1 means the result is already on the MEM/WB forward path.
  always_comb begin
    raw = de_valid && ((de_rs1 != '0 && rs1_cnt > LAT_W'(1)) ||
                       (de_rs2 != '0 && rs2_cnt > LAT_W'(1)));
    waw = de_valid && de_reg_write && de_rd != '0 && rd_cnt > de_lat;
  end

  always_comb begin
    if_stall = 1'b0;
    de_stall = 1'b0;
    de_flush = 1'b0;
    ex_flush = 1'b0;
    if (reset || ex_pc_src) begin
      de_flush = 1'b1;
      ex_flush = 1'b1;
    end else if (raw || waw) begin
      if_stall = 1'b1;
      de_stall = 1'b1;
      ex_flush = 1'b1;
    end
  end

  assign issue = de_valid && !de_stall && !de_flush && de_reg_write && de_rd != '0;

  always_comb begin
    op1_sel = FWD_RF;
    op2_sel = FWD_RF;
    if (!reset) begin
      op1_sel = fwd_pick(ex_rs1, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
      op2_sel = fwd_pick(ex_rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
    end
  end

  assign ex_op1_forward = op1_sel;
  assign ex_op2_forward = op2_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (de_stall && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
      if (de_flush && flush_cycles != '1) flush_cycles <= flush_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Bench for scoreboard_hazard_unit: directed vector table, forwarding cases and
// randomized traffic checked against a ready-time reference model.
module tb_scoreboard_hazard_unit;
  import hazard_pkg::*;

  localparam int NR = 32;
  localparam int CW = 16;

  logic       clk = 1'b0;
  logic       reset, de_valid, de_reg_write, ex_pc_src, mem_reg_write, wb_reg_write;
  logic [4:0] de_rs1, de_rs2, de_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic [3:0] de_lat;
  logic       if_stall, de_stall, de_flush, ex_flush;
  logic [1:0] ex_op1_forward, ex_op2_forward;
  logic [CW-1:0] stall_cycles, flush_cycles;

  always #5 clk = ~clk;

  scoreboard_hazard_unit #(
    .NUM_REGS (32),
    .MAX_LAT  (8),
    .CNT_W    (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .de_valid       (de_valid),
    .de_rs1         (de_rs1),
    .de_rs2         (de_rs2),
    .de_rd          (de_rd),
    .de_reg_write   (de_reg_write),
    .de_lat         (de_lat),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_pc_src      (ex_pc_src),
    .mem_rd         (mem_rd),
    .mem_reg_write  (mem_reg_write),
    .wb_rd          (wb_rd),
    .wb_reg_write   (wb_reg_write),
    .if_stall       (if_stall),
    .de_stall       (de_stall),
    .de_flush       (de_flush),
    .ex_flush       (ex_flush),
    .ex_op1_forward (ex_op1_forward),
    .ex_op2_forward (ex_op2_forward),
    .stall_cycles   (stall_cycles),
    .flush_cycles   (flush_cycles)
  );

  typedef struct {
    logic rst; logic dv; logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd;
    logic rw; logic [3:0] lat; logic [4:0] ers1; logic [4:0] ers2; logic pc;
    logic [4:0] mrd; logic mw; logic [4:0] wrd; logic ww;
  } in_t;

  typedef struct {
    in_t i; logic [2:0] sfe; logic [1:0] fw1; logic [1:0] fw2; int sc; int fc;
  } vec_t;

  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  longint ready_at [NR];
  int     m_sc = 0;
  int     m_fc = 0;
  bit     m_valid = 0;

  // Remaining cycles until register r's producer reaches the forward path.
  function automatic int rem(input logic [4:0] r);
    if (r == 0) return 0;
    return (ready_at[r] > cyc) ? int'(ready_at[r] - cyc) : 0;
  endfunction

  function automatic logic [1:0] fsel(input logic [4:0] r, input logic mw, input logic [4:0] mrd,
                                      input logic ww, input logic [4:0] wrd);
    if (r != 0 && mw && mrd == r) return 2'b10;
    if (r != 0 && ww && wrd == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic vec_t v(input logic rst, input logic dv, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd, input logic rw,
                             input logic [3:0] lat, input logic pc, input logic [2:0] sfe,
                             input int sc, input int fc);
    vec_t x;
    x.i = '{default: '0};
    x.i.rst = rst; x.i.dv = dv; x.i.rs1 = rs1; x.i.rs2 = rs2; x.i.rd = rd;
    x.i.rw = rw; x.i.lat = lat; x.i.pc = pc;
    x.sfe = sfe; x.fw1 = 2'b00; x.fw2 = 2'b00; x.sc = sc; x.fc = fc;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input vec_t x, input bit has_exp);
    in_t  s;
    logic haz, e_st, e_df, e_ef;
    logic [1:0] e_f1, e_f2;
    s = x.i;
    reset = s.rst; de_valid = s.dv; de_rs1 = s.rs1; de_rs2 = s.rs2; de_rd = s.rd;
    de_reg_write = s.rw; de_lat = s.lat; ex_rs1 = s.ers1; ex_rs2 = s.ers2;
    ex_pc_src = s.pc; mem_rd = s.mrd; mem_reg_write = s.mw; wb_rd = s.wrd; wb_reg_write = s.ww;

    haz = s.dv && ((s.rs1 != 0 && rem(s.rs1) > 1) || (s.rs2 != 0 && rem(s.rs2) > 1) ||
                   (s.rw && s.rd != 0 && rem(s.rd) > int'(s.lat)));
    if (s.rst || s.pc) {e_st, e_df, e_ef} = 3'b011;
    else if (haz)      {e_st, e_df, e_ef} = 3'b101;
    else               {e_st, e_df, e_ef} = 3'b000;
    e_f1 = s.rst ? 2'b00 : fsel(s.ers1, s.mw, s.mrd, s.ww, s.wrd);
    e_f2 = s.rst ? 2'b00 : fsel(s.ers2, s.mw, s.mrd, s.ww, s.wrd);

    #4;
    check("de_stall", 32'(de_stall), 32'(e_st));
    check("if_stall", 32'(if_stall), 32'(e_st));
    check("de_flush", 32'(de_flush), 32'(e_df));
    check("ex_flush", 32'(ex_flush), 32'(e_ef));
    check("op1_fwd", 32'(ex_op1_forward), 32'(e_f1));
    check("op2_fwd", 32'(ex_op2_forward), 32'(e_f2));
    if (m_valid) begin
      check("stall_cycles", 32'(stall_cycles), 32'(m_sc));
      check("flush_cycles", 32'(flush_cycles), 32'(m_fc));
    end
    if (has_exp) begin
      check("tbl_stall_flush", 32'({de_stall, de_flush, ex_flush}), 32'(x.sfe));
      check("tbl_op1_fwd", 32'(ex_op1_forward), 32'(x.fw1));
      check("tbl_op2_fwd", 32'(ex_op2_forward), 32'(x.fw2));
      if (x.sc >= 0) check("tbl_stall_cycles", 32'(stall_cycles), 32'(x.sc));
      if (x.fc >= 0) check("tbl_flush_cycles", 32'(flush_cycles), 32'(x.fc));
    end

    @(posedge clk);
    if (s.rst) begin
      for (int r = 0; r < NR; r++) ready_at[r] = 0;
      m_sc = 0; m_fc = 0; m_valid = 1;
    end else begin
      if (s.dv && !e_st && !e_df && s.rw && s.rd != 0) ready_at[s.rd] = cyc + 1 + longint'(s.lat);
      if (e_st && m_sc < 65535) m_sc++;
      if (e_df && m_fc < 65535) m_fc++;
    end
    cyc++;
    #1;
  endtask

  vec_t tbl[$];
  vec_t x;
  in_t  r;

  initial begin
    for (int k = 0; k < NR; k++) ready_at[k] = 0;

    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 3'b011, -1, -1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 2, 1, 4'(LAT_ALU), 0, 3'b000, 0, 0));
    tbl.push_back(v(0, 1, 2, 0, 0, 0, 0, 0, 3'b000, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 2, 1, 4'(LAT_LOAD), 0, 3'b000, 0, 0));
    tbl.push_back(v(0, 1, 2, 0, 0, 0, 0, 0, 3'b101, 0, 0));
    tbl.push_back(v(0, 1, 2, 0, 0, 0, 0, 0, 3'b000, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 5, 1, 6, 0, 3'b000, 1, 0));
    for (int k = 1; k <= 5; k++) tbl.push_back(v(0, 1, 0, 5, 0, 0, 0, 0, 3'b101, k, 0));
    tbl.push_back(v(0, 1, 0, 5, 0, 0, 0, 0, 3'b000, 6, 0));
    tbl.push_back(v(0, 1, 0, 0, 5, 1, 6, 0, 3'b000, 6, 0));
    for (int k = 6; k <= 10; k++) tbl.push_back(v(0, 1, 0, 0, 5, 1, 1, 0, 3'b101, k, 0));
    tbl.push_back(v(0, 1, 0, 0, 5, 1, 1, 0, 3'b000, 11, 0));
    tbl.push_back(v(0, 1, 5, 0, 0, 0, 0, 0, 3'b000, 11, 0));
    tbl.push_back(v(0, 1, 0, 0, 6, 1, 4, 0, 3'b000, 11, 0));
    tbl.push_back(v(0, 1, 6, 0, 6, 1, 1, 1, 3'b011, 11, 0));
    tbl.push_back(v(0, 1, 6, 0, 0, 0, 0, 0, 3'b101, 11, 1));
    tbl.push_back(v(0, 1, 6, 0, 0, 0, 0, 0, 3'b101, 12, 1));
    tbl.push_back(v(0, 1, 6, 0, 0, 0, 0, 0, 3'b000, 13, 1));
    tbl.push_back(v(0, 1, 0, 0, 7, 1, 2, 0, 3'b000, 13, 1));
    tbl.push_back(v(1, 1, 7, 0, 0, 0, 0, 0, 3'b011, 13, 1));
    tbl.push_back(v(0, 1, 7, 0, 0, 0, 0, 0, 3'b000, 0, 0));

    foreach (tbl[k]) step(tbl[k], 1);

    // Forwarding corner cases.
    x = v(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, -1, -1);
    x.i.ers1 = 2; x.i.mrd = 2; x.i.mw = 1; x.fw1 = 2'b10;
    step(x, 1);
    x = v(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, -1, -1);
    x.i.ers2 = 3; x.i.mrd = 3; x.i.mw = 1; x.i.wrd = 3; x.i.ww = 1; x.fw2 = 2'b10;
    step(x, 1);
    x = v(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, -1, -1);
    x.i.ers1 = 4; x.i.mrd = 4; x.i.wrd = 4; x.i.ww = 1; x.fw1 = 2'b01;
    step(x, 1);
    x = v(0, 1, 0, 0, 0, 1, 8, 0, 3'b000, -1, -1);
    x.i.mw = 1; x.i.ww = 1;
    step(x, 1);
    x = v(0, 1, 0, 0, 0, 0, 0, 0, 3'b000, -1, -1);
    step(x, 1);
    x = v(1, 0, 0, 0, 0, 0, 0, 0, 3'b011, -1, -1);
    x.i.ers1 = 9; x.i.ers2 = 9; x.i.mrd = 9; x.i.mw = 1;
    step(x, 1);

    // Randomized traffic over a narrow register range to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      r.rst  = ($urandom_range(0, 63) == 0);
      r.dv   = ($urandom_range(0, 7) != 0);
      r.rs1  = 5'($urandom_range(0, 7));
      r.rs2  = 5'($urandom_range(0, 7));
      r.rd   = 5'($urandom_range(0, 7));
      r.rw   = ($urandom_range(0, 3) != 0);
      r.lat  = 4'($urandom_range(0, 8));
      r.ers1 = 5'($urandom_range(0, 7));
      r.ers2 = 5'($urandom_range(0, 7));
      r.pc   = ($urandom_range(0, 7) == 0);
      r.mrd  = 5'($urandom_range(0, 7));
      r.mw   = 1'($urandom_range(0, 1));
      r.wrd  = 5'($urandom_range(0, 7));
      r.ww   = 1'($urandom_range(0, 1));
      x.i = r;
      step(x, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
